// File: rtl/clk_div_ctrl.sv
// Programmable CPU clock generator: fast / slow / single-step / halt modes.
// CLK_CPU comes straight from a flop; mode changes only take effect at period boundaries.
module clk_div_ctrl #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned FAST_HALF = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             step_btn_i,
  output logic             clk_cpu_o,
  output logic             clk_en_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_FAST = 2'd0;
  localparam logic [1:0] MODE_SLOW = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;
  localparam logic [1:0] MODE_HALT = 2'd3;

  localparam logic [DIV_W-1:0] FAST_H   = DIV_W'(FAST_HALF - 1);
  localparam logic [DIV_W-1:0] HCNT_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [DIV_W-1:0] hcnt_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       mode_q;
  logic             clk_cpu_q;
  logic             clk_en_q;
  logic             busy_q;
  logic [CNT_W-1:0] cycle_cnt_q;

  logic [1:0]       step_sync_q;
  logic             step_prev_q;
  logic [2:0]       step_arm_q;

  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] hcnt_d;
  logic [CNT_W-1:0] cycle_cnt_d;
  logic             at_end;
  logic             run_req;
  logic             step_edge;
  logic             start_req;

  // The arm shift register keeps the edge detector blind until the synchroniser
  // and the previous-sample flop hold real button samples, so a button held
  // through reset release is seen as a level, not a fresh edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      step_sync_q <= 2'b00;
      step_prev_q <= 1'b0;
      step_arm_q  <= 3'b000;
    end else begin
      step_sync_q <= {step_sync_q[0], step_btn_i};
      step_prev_q <= step_sync_q[1];
      step_arm_q  <= {step_arm_q[1:0], 1'b1};
    end
  end

  assign step_edge = step_arm_q[2] & step_sync_q[1] & ~step_prev_q;

  always_comb begin
    half        = (mode_q == MODE_FAST) ? FAST_H : div_q;
    at_end      = (hcnt_q == half);
    hcnt_d      = hcnt_q + HCNT_ONE;
    cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    run_req     = (mode_i == MODE_FAST) || (mode_i == MODE_SLOW);
    start_req   = run_req || ((mode_i == MODE_STEP) && step_edge);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      hcnt_q      <= '0;
      div_q       <= '0;
      mode_q      <= MODE_HALT;
      clk_cpu_q   <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      clk_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            state_q     <= ST_HIGH;
            hcnt_q      <= '0;
            mode_q      <= mode_i;
            div_q       <= div_i;
            clk_cpu_q   <= 1'b1;
            clk_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            cycle_cnt_q <= cycle_cnt_d;
          end
        end
        ST_HIGH: begin
          if (at_end) begin
            state_q   <= ST_LOW;
            hcnt_q    <= '0;
            clk_cpu_q <= 1'b0;
          end else begin
            hcnt_q <= hcnt_d;
          end
        end
        ST_LOW: begin
          if (at_end) begin
            hcnt_q <= '0;
            mode_q <= mode_i;
            div_q  <= div_i;
            // A step or halt request only ever lands here, after a full period.
            if (run_req) begin
              state_q     <= ST_HIGH;
              clk_cpu_q   <= 1'b1;
              clk_en_q    <= 1'b1;
              cycle_cnt_q <= cycle_cnt_d;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            hcnt_q <= hcnt_d;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          hcnt_q    <= '0;
          clk_cpu_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign clk_cpu_o   = clk_cpu_q;
  assign clk_en_o    = clk_en_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign busy_o      = busy_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: vector table, directed corner sequences and a
// randomized run compared every cycle against a period-queue reference model.
module tb_clk_div_ctrl;

  localparam int DW = 8;
  localparam int FH = 2;
  localparam logic [1:0] M_FAST = 2'd0;
  localparam logic [1:0] M_SLOW = 2'd1;
  localparam logic [1:0] M_STEP = 2'd2;
  localparam logic [1:0] M_HALT = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic          step_btn;
  logic          clk_cpu, clk_en, busy;
  logic [31:0]   cycle_cnt;
  logic [1:0]    state;
  logic          clk_cpu4, clk_en4, busy4;
  logic [3:0]    cycle_cnt4;
  logic [1:0]    state4;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_ctrl #(.DIV_W(DW), .FAST_HALF(FH), .CNT_W(32)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode), .div_i(div), .step_btn_i(step_btn),
    .clk_cpu_o(clk_cpu), .clk_en_o(clk_en), .cycle_cnt_o(cycle_cnt), .busy_o(busy),
    .state_o(state)
  );

  clk_div_ctrl #(.DIV_W(DW), .FAST_HALF(FH), .CNT_W(4)) u_w4 (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode), .div_i(div), .step_btn_i(step_btn),
    .clk_cpu_o(clk_cpu4), .clk_en_o(clk_en4), .cycle_cnt_o(cycle_cnt4), .busy_o(busy4),
    .state_o(state4)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each period is scheduled as a queue of upcoming CLK_CPU levels; when the
  // queue runs dry the next period is decided from the live inputs.
  logic        exp_q[$];
  logic        hist[$];
  int          n_edges;
  logic        m_lvl, m_en, m_busy;
  logic [31:0] m_cnt;

  task automatic model_clear();
    exp_q.delete();
    hist.delete();
    n_edges = 0;
    m_lvl = 1'b0; m_en = 1'b0; m_busy = 1'b0; m_cnt = '0;
  endtask

  task automatic model_step();
    logic step_seen;
    int   h;
    hist.push_back(step_btn);
    if (hist.size() > 4) void'(hist.pop_front());
    if (n_edges < 1000) n_edges++;
    step_seen = (n_edges >= 4) && hist[1] && !hist[0];
    m_en = 1'b0;
    if (exp_q.size() == 0) begin
      if (mode == M_FAST || mode == M_SLOW || (!m_busy && mode == M_STEP && step_seen)) begin
        h = (mode == M_FAST) ? FH - 1 : int'(div);
        for (int i = 0; i <= h; i++) exp_q.push_back(1'b1);
        for (int i = 0; i <= h; i++) exp_q.push_back(1'b0);
        m_en  = 1'b1;
        m_cnt = m_cnt + 32'd1;
      end
    end
    if (exp_q.size() > 0) begin
      m_lvl  = exp_q.pop_front();
      m_busy = 1'b1;
    end else begin
      m_lvl  = 1'b0;
      m_busy = 1'b0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else model_step();
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // Every wait goes through here, so the model comparison runs on each cycle.
  task automatic tick();
    logic [1:0] exp_state;
    @(negedge clk);
    exp_state = m_busy ? (m_lvl ? 2'd1 : 2'd2) : 2'd0;
    chk("mon_clk_cpu", clk_cpu, m_lvl);
    chk("mon_clk_en", clk_en, m_en);
    chk("mon_busy", busy, m_busy);
    chk("mon_state", state, exp_state);
    chk("mon_cnt", cycle_cnt, m_cnt);
    chk("mon_cnt4", cycle_cnt4, m_cnt[3:0]);
  endtask

  task automatic wait_en(input string name, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!clk_en && cyc < 1200);
    if (!clk_en) timeout_fail(name);
  endtask

  task automatic measure(output int per, output int hi);
    per = 0;
    hi  = int'(clk_cpu);
    do begin
      tick();
      per++;
      if (clk_cpu && !clk_en) hi++;
    end while (!clk_en && per < 1200);
    if (!clk_en) timeout_fail("measure");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] div;
    int            period;
    int            high;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c, per, hi, start_cnt, en_cnt, lo_cnt, r;

    vecs[0] = '{M_FAST, 8'd0,   4,   2};
    vecs[1] = '{M_SLOW, 8'd0,   2,   1};
    vecs[2] = '{M_SLOW, 8'd1,   4,   2};
    vecs[3] = '{M_SLOW, 8'd6,   14,  7};
    vecs[4] = '{M_FAST, 8'd200, 4,   2};
    vecs[5] = '{M_SLOW, 8'd255, 512, 256};

    rst_n = 1'b0; mode = M_FAST; div = '0; step_btn = 1'b0;
    #3;
    chk("rst_clk_cpu", clk_cpu, 0);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    repeat (2) tick();

    // Fast mode from reset: first rise one cycle after release, 10 rises in 40.
    rst_n = 1'b1;
    tick();
    chk("fast_first_rise", clk_cpu, 1);
    chk("fast_first_en", clk_en, 1);
    repeat (39) tick();
    chk("fast_cnt_40", cycle_cnt, 10);

    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      div  = vecs[i].div;
      wait_en("vec_settle_a", c);
      wait_en("vec_settle_b", c);
      measure(per, hi);
      chk($sformatf("vec%0d_period", i), per, vecs[i].period);
      chk($sformatf("vec%0d_high", i), hi, vecs[i].high);
    end

    // DIV change mid-HIGH only affects the following period.
    mode = M_SLOW; div = 8'd255;
    wait_en("div_sync", c);
    repeat (10) tick();
    div = 8'd3;
    wait_en("div_cur", c);
    chk("div_cur_rest", c, 502);
    wait_en("div_next", c);
    chk("div_next_period", c, 8);

    // Halt requested mid-HIGH: period completes, then clock parks low.
    mode = M_FAST;
    wait_en("halt_sync", c);
    mode = M_HALT;
    tick(); chk("halt_hi_keep", clk_cpu, 1);
    tick(); chk("halt_lo1", clk_cpu, 0); chk("halt_lo1_busy", busy, 1);
    tick(); chk("halt_lo2", clk_cpu, 0); chk("halt_lo2_busy", busy, 1);
    tick(); chk("halt_idle_busy", busy, 0);
    repeat (3) tick();
    chk("halt_parked", clk_cpu, 0);
    mode = M_FAST;
    tick();
    chk("resume_rise", clk_cpu, 1);
    chk("resume_en", clk_en, 1);

    // Single step with DIV=1; a second press while busy is dropped.
    mode = M_HALT;
    c = 0;
    while (busy && c < 50) begin tick(); c++; end
    if (busy) timeout_fail("step_idle_wait");
    mode = M_STEP; div = 8'd1;
    repeat (5) tick();
    start_cnt = int'(m_cnt);
    hi = 0; en_cnt = 0; lo_cnt = 0;
    step_btn = 1'b1; tick();
    step_btn = 1'b0; tick();
    step_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 3) step_btn = 1'b0;
      if (clk_cpu) hi++;
      if (clk_en) en_cnt++;
      if (busy && !clk_cpu) lo_cnt++;
    end
    chk("step_high_cycles", hi, 2);
    chk("step_low_cycles", lo_cnt, 2);
    chk("step_en_pulses", en_cnt, 1);
    chk("step_cnt", cycle_cnt, start_cnt + 1);
    chk("step_idle", busy, 0);

    // Button held through reset release must not produce a step.
    rst_n = 1'b0; step_btn = 1'b1; mode = M_STEP;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("held_btn_busy", busy, 0);
    chk("held_btn_cnt", cycle_cnt, 0);

    // 4-bit counter wraps after 16 rises; async reset mid-HIGH.
    step_btn = 1'b0; mode = M_FAST;
    for (int k = 0; k < 16; k++) wait_en("wrap_rise", c);
    chk("wrap_cnt4", cycle_cnt4, 0);
    chk("wrap_cnt32", cycle_cnt, 16);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk_cpu", clk_cpu, 0);
    chk("async_rst_clk_cpu4", clk_cpu4, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", cycle_cnt, 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Randomized run against the reference model.
    for (int k = 0; k < 4000; k++) begin
      tick();
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 9);
        mode = (r < 3) ? M_FAST : (r < 6) ? M_SLOW : (r < 8) ? M_STEP : M_HALT;
      end
      if ($urandom_range(0, 29) == 0)
        div = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) step_btn = ~step_btn;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
